// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants (parity modes, default FIFO depth and divisor width)
package uart_pkg;
    localparam logic PARITY_ODD    = 1'b0;
    localparam logic PARITY_EVEN   = 1'b1;
    localparam int   DEFAULT_DEPTH = 8;
    localparam int   DEFAULT_DIV_W = 16;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: first-word fall-through synchronous FIFO with occupancy count
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [LW-1:0]    level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // a pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside a pop
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign empty   = level == '0;
    assign full    = level == LW'(DEPTH);
    assign dout    = mem[rd_ptr];

    // pointers wrap naturally at DEPTH (power of 2); level tracks net push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            level <= (do_push && !do_pop) ? level + 1'b1 :
                     (do_pop && !do_push) ? level - 1'b1 : level;
        end
    end

    // storage is intentionally left unreset
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversample tick generator, RX byte FIFO, sticky errors and interrupt
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int DIV_W = DEFAULT_DIV_W,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_en,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             cfg_parity_en,
    input  logic             cfg_parity_even,
    output logic             os_tick,
    output logic             parity_enable_o,
    output logic             parity_mode_o,
    input  logic             rx_done_tick,
    input  logic [7:0]       rx_data,
    input  logic             rx_error,
    input  logic             rd_en,
    output logic [7:0]       rd_data,
    output logic             rx_empty,
    output logic             rx_full,
    output logic [LW-1:0]    rx_level,
    input  logic [LW-1:0]    irq_thresh,
    input  logic             irq_en,
    input  logic             err_clr,
    output logic             overrun_err,
    output logic             parity_err,
    output logic             irq
);
    logic [DIV_W-1:0] cnt;
    logic             rx_error_q;
    logic             push_req;
    logic             pop_ok;
    logic             overrun_set;
    logic             parity_set;

    assign push_req    = rx_done_tick & rx_en & ~rx_error;
    assign pop_ok      = rd_en & ~rx_empty;
    assign overrun_set = push_req & rx_full & ~pop_ok;
    assign parity_set  = rx_error & ~rx_error_q;

    // tick counter: >= compare lets a shrunken divisor wrap immediately instead of running to 2^DIV_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            os_tick <= 1'b0;
        end else if (!rx_en) begin
            cnt     <= '0;
            os_tick <= 1'b0;
        end else begin
            cnt     <= (cnt >= baud_div) ? '0 : cnt + 1'b1;
            os_tick <= cnt >= baud_div;
        end
    end

    // registered copies of the parity configuration for the receiver
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_enable_o <= 1'b0;
            parity_mode_o   <= PARITY_ODD;
        end else begin
            parity_enable_o <= cfg_parity_en;
            parity_mode_o   <= cfg_parity_even;
        end
    end

    // sticky error flags; a set in the same cycle as err_clr keeps the flag high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_error_q  <= 1'b0;
            overrun_err <= 1'b0;
            parity_err  <= 1'b0;
        end else begin
            rx_error_q  <= rx_error;
            overrun_err <= overrun_set | (overrun_err & ~err_clr);
            parity_err  <= parity_set | (parity_err & ~err_clr);
        end
    end

    // level interrupt (disabled by a zero threshold) or-ed with the sticky errors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq <= 1'b0;
        else irq <= irq_en & (((irq_thresh != '0) & (rx_level >= irq_thresh)) | overrun_err | parity_err);
    end

    uart_sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_req),
        .pop   (rd_en),
        .din   (rx_data),
        .dout  (rd_data),
        .empty (rx_empty),
        .full  (rx_full),
        .level (rx_level)
    );
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: randomized scoreboard bench with a queue-based reference model
module tb_uart_rx_ctrl;
    localparam int DEPTH = 8;
    localparam int DIV_W = 16;
    localparam int LW    = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             rx_en;
    logic [DIV_W-1:0] baud_div;
    logic             cfg_parity_en;
    logic             cfg_parity_even;
    logic             os_tick;
    logic             parity_enable_o;
    logic             parity_mode_o;
    logic             rx_done_tick;
    logic [7:0]       rx_data;
    logic             rx_error;
    logic             rd_en;
    logic [7:0]       rd_data;
    logic             rx_empty;
    logic             rx_full;
    logic [LW-1:0]    rx_level;
    logic [LW-1:0]    irq_thresh;
    logic             irq_en;
    logic             err_clr;
    logic             overrun_err;
    logic             parity_err;
    logic             irq;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic m_ov = 1'b0, m_pe = 1'b0, m_irq = 1'b0, m_err_prev = 1'b0, m_pen = 1'b0, m_pmode = 1'b0;

    uart_rx_ctrl #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx_en           (rx_en),
        .baud_div        (baud_div),
        .cfg_parity_en   (cfg_parity_en),
        .cfg_parity_even (cfg_parity_even),
        .os_tick         (os_tick),
        .parity_enable_o (parity_enable_o),
        .parity_mode_o   (parity_mode_o),
        .rx_done_tick    (rx_done_tick),
        .rx_data         (rx_data),
        .rx_error        (rx_error),
        .rd_en           (rd_en),
        .rd_data         (rd_data),
        .rx_empty        (rx_empty),
        .rx_full         (rx_full),
        .rx_level        (rx_level),
        .irq_thresh      (irq_thresh),
        .irq_en          (irq_en),
        .err_clr         (err_clr),
        .overrun_err     (overrun_err),
        .parity_err      (parity_err),
        .irq             (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        chk("level", 32'(rx_level), 32'(exp_q.size()));
        chk("empty", 32'(rx_empty), 32'(exp_q.size() == 0));
        chk("full", 32'(rx_full), 32'(exp_q.size() == DEPTH));
        chk("overrun_err", 32'(overrun_err), 32'(m_ov));
        chk("parity_err", 32'(parity_err), 32'(m_pe));
        chk("irq", 32'(irq), 32'(m_irq));
        chk("parity_enable_o", 32'(parity_enable_o), 32'(m_pen));
        chk("parity_mode_o", 32'(parity_mode_o), 32'(m_pmode));
        if (exp_q.size() != 0) chk("head", 32'(rd_data), 32'(exp_q[0]));
    endtask

    // one bus cycle: check current state, apply inputs, advance the model, step to after the edge
    task automatic cyc(input logic rd, input logic done, input logic [7:0] d, input logic err, input logic clr);
        int   lvl;
        logic popv, pushr;
        check_state();
        rd_en = rd; rx_done_tick = done; rx_data = d; rx_error = err; err_clr = clr;
        lvl   = exp_q.size();
        popv  = rd && lvl > 0;
        pushr = done && rx_en && !err;
        m_irq = irq_en && ((irq_thresh != 0 && lvl >= int'(irq_thresh)) || m_ov || m_pe);
        m_ov  = (pushr && lvl == DEPTH && !popv) || (m_ov && !clr);
        m_pe  = (err && !m_err_prev) || (m_pe && !clr);
        m_err_prev = err;
        m_pen = cfg_parity_en;
        m_pmode = cfg_parity_even;
        if (pushr && (lvl < DEPTH || popv)) exp_q.push_back(d);
        @(posedge clk); #2;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // monitor: every DUT pop must present the oldest byte the model still holds
    always @(negedge clk) begin
        if (rst_n && rd_en && !rx_empty) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_data: DUT popped %0h while model holds 0 bytes", rd_data);
            end else begin
                chk("pop_data", 32'(rd_data), 32'(exp_q[0]));
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        logic err_lvl;
        int   rd_pct;
        rst_n = 1'b0; rx_en = 1'b0; baud_div = '0; cfg_parity_en = 1'b0; cfg_parity_even = 1'b0;
        rx_done_tick = 1'b0; rx_data = '0; rx_error = 1'b0; rd_en = 1'b0;
        irq_thresh = '0; irq_en = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_os_tick", 32'(os_tick), 0);
        chk("rst_empty", 32'(rx_empty), 1);
        chk("rst_full", 32'(rx_full), 0);
        chk("rst_level", 32'(rx_level), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_ov", 32'(overrun_err), 0);
        chk("rst_pe", 32'(parity_err), 0);
        chk("rst_pen", 32'(parity_enable_o), 0);
        rst_n = 1'b1;
        @(posedge clk); #2;

        // tick period baud_div+1, first tick baud_div+1 edges after enabling
        baud_div = 16'd3; rx_en = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #2;
            chk("tick_div3", 32'(os_tick), 32'(i % 4 == 0));
        end
        rx_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #2;
            chk("tick_disabled", 32'(os_tick), 0);
        end
        baud_div = 16'd0; rx_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            chk("tick_div0", 32'(os_tick), 1);
        end
        rx_en = 1'b0;
        @(posedge clk); #2;
        baud_div = 16'd10; rx_en = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk); #2;
            chk("tick_div10", 32'(os_tick), 0);
        end
        baud_div = 16'd3;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #2;
            chk("tick_shrink", 32'(os_tick), 32'(i % 4 == 1));
        end

        // fill to full, then overrun keeps the head
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
        idle();
        chk("ovr_flag", 32'(overrun_err), 1);
        chk("ovr_head", 32'(rd_data), 32'h11);
        chk("ovr_level", 32'(rx_level), DEPTH);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
        idle();
        chk("full_pp_level", 32'(rx_level), DEPTH);
        chk("full_pp_ov", 32'(overrun_err), 0);
        for (int i = 0; i < DEPTH + 2; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("drained", 32'(rx_empty), 1);
        cyc(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
        idle();
        chk("empty_pp_level", 32'(rx_level), 1);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // level interrupt
        irq_thresh = 4'd3; irq_en = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        chk("irq_lat", 32'(irq), 0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("irq_set", 32'(irq), 1);
        idle();
        chk("irq_clr", 32'(irq), 0);
        irq_en = 1'b0; irq_thresh = '0;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // parity error: one set per rising edge, errored bytes dropped
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 8'hE0, 1'b1, 1'b0);
        chk("par_set", 32'(parity_err), 1);
        chk("par_nopush", 32'(rx_empty), 1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("par_once", 32'(parity_err), 0);
        idle();
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("par_set_wins", 32'(parity_err), 1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // randomized traffic alternating drain-heavy and fill-heavy phases
        err_lvl = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 63) == 0) rx_en = ~rx_en;
            if ($urandom_range(0, 99) == 0) irq_thresh = LW'($urandom_range(0, DEPTH));
            if ($urandom_range(0, 99) == 0) irq_en = ~irq_en;
            if ($urandom_range(0, 49) == 0) cfg_parity_en = ~cfg_parity_en;
            if ($urandom_range(0, 49) == 0) cfg_parity_even = ~cfg_parity_even;
            if ($urandom_range(0, 15) == 0) err_lvl = ~err_lvl;
            rd_pct = ((n / 250) % 2 == 1) ? 75 : 20;
            cyc(1'(int'($urandom_range(0, 99)) < rd_pct), 1'($urandom_range(0, 1)), 8'($urandom),
                err_lvl, 1'($urandom_range(0, 19) == 0));
        end

        // asynchronous reset with bytes buffered
        rx_en = 1'b1; irq_en = 1'b1; irq_thresh = 4'd2;
        cfg_parity_en = 1'b0; cfg_parity_even = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0);
        idle();
        chk("pre_rst_irq", 32'(irq), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_empty", 32'(rx_empty), 1);
        chk("arst_level", 32'(rx_level), 0);
        chk("arst_irq", 32'(irq), 0);
        chk("arst_tick", 32'(os_tick), 0);
        exp_q.delete();
        m_ov = 1'b0; m_pe = 1'b0; m_irq = 1'b0; m_err_prev = 1'b0; m_pen = 1'b0; m_pmode = 1'b0;
        baud_div = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            chk("rst_no_tick", 32'(os_tick), 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #2;
        chk("post_rst_tick", 32'(os_tick), 1);
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
